// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master command port among NREQ requesters.
// Watches the bus SETUP/ACCESS phases and returns done plus read data.
module apb_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic                     pclk,
    input  logic                     preset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     transfer,
    output logic                     read_write,
    output logic [ADDR_W-1:0]        apb_read_addr,
    output logic [ADDR_W-1:0]        apb_write_addr,
    output logic [DATA_W-1:0]        apb_write_data,
    input  logic [DATA_W-1:0]        apb_read_data,
    input  logic                     pselx,
    input  logic                     penable,
    input  logic                     pready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic [IW-1:0] pick;
    logic          found;
    logic          xfer_q;
    logic          cpl;

    assign cpl      = pselx & penable & pready;
    // Dropped in the completion cycle so the master goes back to IDLE.
    assign transfer = xfer_q & ~cpl;

    always_comb begin : arb_sel
        int            j;
        logic [IW-1:0] jj;
        pick  = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IW'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                pick  = jj;
            end
        end
    end

    always_comb begin
        read_write     = 1'b0;
        apb_read_addr  = '0;
        apb_write_addr = '0;
        apb_write_data = '0;
        if (|gnt) begin
            read_write     = req_wr[gidx];
            apb_read_addr  = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
            apb_write_addr = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
            apb_write_data = req_wdata[int'(gidx)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state  <= IDLE;
            ptr    <= '0;
            gidx   <= '0;
            gnt    <= '0;
            done   <= '0;
            rdata  <= '0;
            xfer_q <= 1'b0;
        end else begin
            done <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        gidx   <= pick;
                        xfer_q <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (cpl) begin
                        if (!read_write) rdata <= apb_read_data;
                        done   <= gnt;
                        gnt    <= '0;
                        xfer_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: behavioural APB master/slave plus a
// scoreboard of expected completions.
module tb_apb_rr_arbiter;

    logic        pclk;
    logic        preset_n;
    logic [3:0]  req;
    logic [3:0]  req_wr;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [15:0] rdata;
    logic        transfer;
    logic        read_write;
    logic [3:0]  apb_read_addr;
    logic [3:0]  apb_write_addr;
    logic [15:0] apb_write_data;
    logic [15:0] apb_read_data;
    logic        pselx;
    logic        penable;
    logic        pready;

    apb_rr_arbiter #(.NREQ(4), .ADDR_W(4), .DATA_W(16)) dut (
        .pclk           (pclk),
        .preset_n       (preset_n),
        .req            (req),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .gnt            (gnt),
        .done           (done),
        .rdata          (rdata),
        .transfer       (transfer),
        .read_write     (read_write),
        .apb_read_addr  (apb_read_addr),
        .apb_write_addr (apb_write_addr),
        .apb_write_data (apb_write_data),
        .apb_read_data  (apb_read_data),
        .pselx          (pselx),
        .penable        (penable),
        .pready         (pready)
    );

    typedef struct {
        logic [3:0]  g;
        logic        wr;
        logic [3:0]  a;
        logic [15:0] wd;
        logic [15:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ws = 0;
    int   wcnt = 0;
    logic [15:0] slave_rdata;
    logic [3:0]  prev_gnt;
    logic        cpl_tb;

    typedef enum {M_IDLE, M_SETUP, M_ACCESS} mph_t;
    mph_t ph;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // APB master reacting to transfer, slave with programmable wait states.
    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ph   <= M_IDLE;
            wcnt <= 0;
        end else begin
            case (ph)
                M_IDLE:   if (transfer) ph <= M_SETUP;
                M_SETUP:  begin ph <= M_ACCESS; wcnt <= ws; end
                M_ACCESS: begin
                    if (pready) ph <= transfer ? M_SETUP : M_IDLE;
                    else wcnt <= wcnt - 1;
                end
                default:  ph <= M_IDLE;
            endcase
        end
    end

    assign pselx         = (ph != M_IDLE);
    assign penable       = (ph == M_ACCESS);
    assign pready        = penable && (wcnt == 0);
    assign apb_read_data = slave_rdata;
    assign cpl_tb        = pselx & penable & pready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (preset_n) begin
            chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            chk("done_onehot", 32'($onehot0(done)), 32'd1);
            if (cpl_tb) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL sb_cpl: observed=cpl expected=no transfer");
                end else begin
                    chk("cpl_rw", 32'(read_write), 32'(exp_q[0].wr));
                    chk("cpl_raddr", 32'(apb_read_addr), 32'(exp_q[0].a));
                    chk("cpl_waddr", 32'(apb_write_addr), 32'(exp_q[0].a));
                    chk("cpl_wdata", 32'(apb_write_data), 32'(exp_q[0].wd));
                end
            end
            if (|done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL sb_done: observed=%0h expected=none", done);
                end else begin
                    chk("done_id", 32'(done), 32'(exp_q[0].g));
                    chk("done_prev_gnt", 32'(done & prev_gnt), 32'(done));
                    if (!exp_q[0].wr) chk("rdata", 32'(rdata), 32'(exp_q[0].rd));
                    void'(exp_q.pop_front());
                end
            end
            prev_gnt <= gnt;
        end else begin
            prev_gnt <= '0;
        end
    end

    task automatic set_req(input int i, input logic wr, input logic [3:0] a, input logic [15:0] d);
        req_wr[i]          = wr;
        req_addr[i*4 +: 4] = a;
        req_wdata[i*16 +: 16] = d;
        req[i]             = 1'b1;
    endtask

    task automatic push(input int i, input logic wr, input logic [3:0] a,
                        input logic [15:0] d, input logic [15:0] r);
        exp_t e;
        e.g  = 4'(1 << i);
        e.wr = wr;
        e.a  = a;
        e.wd = d;
        e.rd = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int max);
        bit got = 1'b0;
        for (int k = 0; k < max && !got; k++) begin
            @(negedge pclk);
            if (pselx && !cpl_tb) chk("xfer_hold", 32'(transfer), 32'd1);
            if (cpl_tb) chk("xfer_drop", 32'(transfer), 32'd0);
            if (|done) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $error("FAIL done_timeout: observed=no done expected=done within %0d", max);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_xfer"}, 32'(transfer), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_rw"}, 32'(read_write), 32'd0);
        chk({tag, "_addr"}, 32'({apb_read_addr, apb_write_addr}), 32'd0);
        chk({tag, "_wdata"}, 32'(apb_write_data), 32'd0);
    endtask

    initial begin
        int t0;
        int dc[5];
        bit seen;
        pclk = 1'b0; preset_n = 1'b0;
        req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        slave_rdata = '0; prev_gnt = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk_zero("reset");
        @(posedge pclk); #1 preset_n = 1'b1;

        // single zero-wait write from requester 2
        @(posedge pclk); #1;
        ws = 0;
        set_req(2, 1'b1, 4'h5, 16'hA5A5);
        push(2, 1'b1, 4'h5, 16'hA5A5, 16'h0);
        t0 = cyc;
        @(negedge pclk); chk("t0_gnt", 32'(gnt), 32'd0);
        @(negedge pclk); chk("t1_gnt", 32'(gnt), 32'h4);
        chk("t1_xfer", 32'(transfer), 32'd1);
        @(negedge pclk); chk("t2_setup", 32'({pselx, penable}), 32'b10);
        chk("t2_xfer", 32'(transfer), 32'd1);
        wait_done(20);
        chk("wr_lat", 32'(cyc - t0), 32'd4);
        chk("wr_gnt_clr", 32'(gnt), 32'd0);
        #1 req = '0;

        // pointer now 3: 3 beats 0, then 0 follows
        @(posedge pclk); #1;
        set_req(0, 1'b1, 4'h1, 16'h0101);
        set_req(3, 1'b1, 4'hE, 16'h3E3E);
        push(3, 1'b1, 4'hE, 16'h3E3E, 16'h0);
        push(0, 1'b1, 4'h1, 16'h0101, 16'h0);
        wait_done(20);
        chk("ptr_first", 32'(done), 32'h8);
        #1 req[3] = 1'b0;
        wait_done(20);
        chk("ptr_second", 32'(done), 32'h1);
        #1 req = '0;

        // read with three wait states
        @(posedge pclk); #1;
        ws = 3; slave_rdata = 16'h1234;
        set_req(0, 1'b0, 4'h9, 16'h0);
        push(0, 1'b0, 4'h9, 16'h0, 16'h1234);
        t0 = cyc;
        wait_done(30);
        chk("rd_lat", 32'(cyc - t0), 32'd7);
        chk("rd_data", 32'(rdata), 32'h1234);
        #1 req = '0;

        // all four requesting continuously from reset
        @(posedge pclk); #1 preset_n = 1'b0;
        ws = 0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b1, 4'(i + 4), 16'(16'h1100 * (i + 1)));
            push(i, 1'b1, 4'(i + 4), 16'(16'h1100 * (i + 1)), 16'h0);
        end
        push(0, 1'b1, 4'h4, 16'h1100, 16'h0);
        @(posedge pclk); #1 preset_n = 1'b1;
        t0 = cyc;
        for (int n = 0; n < 5; n++) begin
            wait_done(20);
            dc[n] = cyc;
            chk("rr_order", 32'(done), 32'(1 << (n % 4)));
        end
        #1 req = '0;
        chk("rr_first_lat", 32'(dc[0] - t0), 32'd4);
        for (int n = 1; n < 5; n++) chk("rr_spacing", 32'(dc[n] - dc[n-1]), 32'd5);

        // requester 1 drops req during the transfer
        @(posedge pclk); #1;
        ws = 2;
        set_req(1, 1'b1, 4'h6, 16'h6161);
        push(1, 1'b1, 4'h6, 16'h6161, 16'h0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge pclk);
            if (pselx && !penable) seen = 1'b1;
        end
        chk("drop_setup_seen", 32'(seen), 32'd1);
        #1 req = '0;
        wait_done(20);
        chk("drop_done", 32'(done), 32'h2);
        repeat (3) begin
            @(negedge pclk);
            chk("drop_no_gnt", 32'(gnt), 32'd0);
        end

        // reset in the middle of a transfer
        @(posedge pclk); #1;
        ws = 5;
        set_req(2, 1'b1, 4'hB, 16'hBBBB);
        push(2, 1'b1, 4'hB, 16'hBBBB, 16'h0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge pclk);
            if (penable) seen = 1'b1;
        end
        chk("rst_access_seen", 32'(seen), 32'd1);
        chk("rst_pre_gnt", 32'(gnt), 32'h4);
        #1 preset_n = 1'b0;
        #1 chk_zero("midrst");
        exp_q.delete();
        req = '0;
        repeat (2) @(posedge pclk);
        #1 ws = 0;
        set_req(1, 1'b1, 4'h2, 16'h2222);
        set_req(3, 1'b1, 4'hC, 16'h3C3C);
        push(1, 1'b1, 4'h2, 16'h2222, 16'h0);
        push(3, 1'b1, 4'hC, 16'h3C3C, 16'h0);
        @(posedge pclk); #1 preset_n = 1'b1;
        t0 = cyc;
        wait_done(20);
        chk("post_rst_lat", 32'(cyc - t0), 32'd4);
        chk("post_rst_ptr0", 32'(done), 32'h2);
        #1 req[1] = 1'b0;
        wait_done(20);
        chk("post_rst_req3", 32'(done), 32'h8);
        #1 req = '0;

        // write after read leaves rdata untouched
        @(posedge pclk); #1;
        slave_rdata = 16'hBEEF;
        set_req(0, 1'b0, 4'h3, 16'h0);
        push(0, 1'b0, 4'h3, 16'h0, 16'hBEEF);
        wait_done(20);
        #1 req = '0;
        @(posedge pclk); #1;
        slave_rdata = 16'hDEAD;
        set_req(1, 1'b1, 4'h7, 16'h1111);
        push(1, 1'b1, 4'h7, 16'h1111, 16'h0);
        wait_done(20);
        #1 req = '0;
        repeat (2) @(negedge pclk);
        chk("war_rdata", 32'(rdata), 32'hBEEF);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Round-robin arbiter that shares the single APB master command port between NREQ local requesters.
- Grants one requester at a time and drives the master's transfer/read_write/address/write-data inputs from the granted requester's command.
- Tracks the APB SETUP/ACCESS phases on the bus to detect completion, then returns a done pulse and captured read data to the winner.
- Sits between the block-level requesters and the APB master instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 4, APB address width; matches the master address ports.
- DATA_W, 16, APB data width; matches the master data ports.

Ports:
- pclk  in  1  APB clock.
- preset_n  in  1  Reset, asynchronous, active-low.
- req  in  NREQ  Per-requester request level; held until the matching done.
- req_wr  in  NREQ  Per-requester direction, 1 = write.
- req_addr  in  NREQ*ADDR_W  Packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  Packed write data; same packing as req_addr.
- gnt  out  NREQ  One-hot grant, registered.
- done  out  NREQ  One-cycle completion pulse to the granted requester, registered.
- rdata  out  DATA_W  Read data captured at read completion; held until the next read completes.
- transfer  out  1  To master transfer.
- read_write  out  1  To master read_write; equals req_wr of the granted requester.
- apb_read_addr  out  ADDR_W  To master; granted address.
- apb_write_addr  out  ADDR_W  To master; granted address.
- apb_write_data  out  DATA_W  To master; granted write data.
- apb_read_data  in  DATA_W  From master.
- pselx  in  1  Monitored APB bus select.
- penable  in  1  Monitored APB bus enable.
- pready  in  1  Monitored APB bus ready.

Behaviour:
- Reset values:
  - state = IDLE; pointer = 0; gnt = 0; done = 0; rdata = 0; transfer = 0.
  - read_write, addresses and write data = 0.
- Reset mid-transaction: all of the above are forced immediately; no done is issued for the aborted transfer.
- cpl = pselx & penable & pready (the ACCESS completion cycle).
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit searching from pointer upward, wrapping modulo NREQ.
  - Register gnt one-hot and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: transfer = 1. Go to WAIT unconditionally; the master enters SETUP next cycle.
- WAIT:
  - transfer = !cpl, so it is deasserted in the completion cycle and the master returns to IDLE instead of starting a new SETUP.
  - On cpl: if read_write = 0, rdata <= apb_read_data. Then go to DONE.
  - Each pready-low cycle extends WAIT by one cycle. There is no timeout.
- DONE:
  - done[granted] = 1 for exactly one cycle; gnt cleared at the same edge.
  - pointer <= (granted index + 1) mod NREQ. Go to IDLE.
  - Requests are not evaluated in DONE.
- Command mux: read_write, apb_read_addr, apb_write_addr and apb_write_data come from the granted requester's fields while gnt != 0; all are 0 when gnt == 0.
- Latency with a zero-wait slave: req seen in IDLE at cycle t0 -> gnt at t1 (ISSUE) -> master SETUP at t2 -> ACCESS/cpl at t3 -> done at t4.
  - Minimum spacing between back-to-back grants is 5 cycles (the extra IDLE cycle).
- Requester contract:
  - Fields stay stable from req rise until done.
  - Dropping req while granted does not abort the transfer; it completes and done is still pulsed.
  - A requester wanting another transfer keeps req high after done; it then competes at lowest priority relative to the new pointer.
- Simultaneous requests: only one winner per IDLE cycle; the others wait with no starvation. The worst-case wait is NREQ-1 transactions.
- gnt and done are never multi-hot. A done bit never asserts without the corresponding gnt having been high in the previous cycle.

Test Plan:
- Single write, zero-wait:
  - Stimulus: req[2]=1, wr=1, addr=0x5, wdata=0xA5A5.
  - Required: gnt=0100 at t1; transfer high t1-t2 and low t3; slave sees paddr=5, pwdata=0xA5A5; done[2] at t4; pointer becomes 3.
- Read with 3 wait states:
  - Stimulus: req[0] read, addr=0x9; slave prdata=0x1234, pready low for 3 ACCESS cycles.
  - Required: done[0] at t7; rdata=0x1234; transfer stays 1 until the pready cycle.
- All four requesting continuously from reset:
  - Required: grant order 0,1,2,3,0; each gnt held for one transaction; done pulses 5 cycles apart with a zero-wait slave.
- Requester 1 drops req during WAIT:
  - Required: the transfer still completes and done[1] pulses; no new grant until IDLE.
- preset_n low during WAIT:
  - Required: gnt, done, transfer, rdata and the command outputs go to 0 immediately; pointer = 0; after release, req[3] is granted normally.
- Write after read:
  - Stimulus: a write following a read.
  - Required: rdata retains the read value (unchanged by the write).
